// File: rtl/expr_pkg.sv
// Shared op codes, level/state enums and helpers for the expression stream generator.
package expr_pkg;

    localparam logic [3:0] OP_ADD = 4'hA;
    localparam logic [3:0] OP_SUB = 4'hB;
    localparam logic [3:0] OP_MUL = 4'hC;
    localparam logic [3:0] OP_DIV = 4'hD;

    typedef enum logic [1:0] {
        LVL_0 = 2'd0,
        LVL_1 = 2'd1,
        LVL_2 = 2'd2
    } level_e;

    typedef enum logic [1:0] {
        ST_DRAW  = 2'd0,
        ST_CHECK = 2'd1,
        ST_VALID = 2'd2
    } state_e;

    // Shift-left Fibonacci tap masks: bit (e-1) set for each polynomial term x^e.
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            24:      return 32'h00E1_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_B400;
        endcase
    endfunction

    function automatic logic [3:0] draw_operand(input logic [5:0] raw, input int num_max);
        return 4'(int'(raw) % num_max + 1);
    endfunction

endpackage

// File: rtl/expr_stream_gen_if.sv
// Valid/ready expression stream from the generator to the display/answer logic.
interface expr_stream_gen_if;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] exp;
    logic [1:0]  lane;

    modport master (output out_valid, exp, lane, input out_ready);
    modport slave  (input out_valid, exp, lane, output out_ready);
endinterface

// File: rtl/lfsr_core.sv
// Free-running Fibonacci LFSR with zero-state recovery and seed load; exposes the low 16 bits.
module lfsr_core
    import expr_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(16'hACE1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    output logic [15:0]      lfsr_lo
);
    localparam logic [31:0]      TAPS_ALL = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];

    logic [WIDTH-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
        if (seed_load) begin
            lfsr_d = (seed == '0) ? SEED : seed;
        end else if (lfsr_q == '0) begin
            lfsr_d = SEED;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr_q <= SEED;
        else      lfsr_q <= lfsr_d;
    end

    assign lfsr_lo = lfsr_q[15:0];
endmodule

// File: rtl/expr_stream_gen.sv
// Streams random arithmetic expressions with score-scaled difficulty over a valid/ready port.
// Optional seed reload ports are enabled by defining EXPR_GEN_SEED_EN.
//
// state    | meaning
// DRAW     | sample operand/op/lane fields from the LFSR and latch the difficulty level
// CHECK    | apply op fixups; redraw on a non-exact division, otherwise load the output
// VALID    | hold exp/lane until the consumer takes them
module expr_stream_gen
    import expr_pkg::*;
#(
    parameter int          LFSR_W    = 16,
    parameter logic [31:0] SEED      = 32'h0000_ACE1,
    parameter int          NUM_MAX   = 9,
    parameter int          LANES     = 3,
    parameter int          SCORE_W   = 7,
    parameter int          THRESH1   = 10,
    parameter int          THRESH2   = 20,
    parameter int          MAX_RETRY = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SCORE_W-1:0] score,
`ifdef EXPR_GEN_SEED_EN
    input  logic               seed_load,
    input  logic [LFSR_W-1:0]  seed,
`endif
    expr_stream_gen_if.master  out_if
);
    localparam int                 RETRY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

    state_e             state_q, state_d;
    level_e             level_q, level_d;
    logic [5:0]         a_raw_q, a_raw_d, b_raw_q, b_raw_d;
    logic [1:0]         op_raw_q, op_raw_d, ln_raw_q, ln_raw_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [11:0]        exp_q, exp_d;
    logic [1:0]         lane_q, lane_d, prev_lane_q, prev_lane_d;
    logic               valid_q, valid_d;

    logic [15:0]        lfsr_lo;
    logic               seed_load_i;
    logic [LFSR_W-1:0]  seed_i;
    logic [3:0]         a0, b0, op, a_fix, b_fix;
    logic [6:0]         prod;
    logic               div_fits, div_reject;
    logic [1:0]         l0, lane_pick;

`ifdef EXPR_GEN_SEED_EN
    assign seed_load_i = seed_load;
    assign seed_i      = seed;
`else
    assign seed_load_i = 1'b0;
    assign seed_i      = '0;
`endif

    lfsr_core #(
        .WIDTH (LFSR_W),
        .SEED  (SEED[LFSR_W-1:0])
    ) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_load_i),
        .seed      (seed_i),
        .lfsr_lo   (lfsr_lo)
    );

    always_comb begin
        a0 = draw_operand(a_raw_q, NUM_MAX);
        b0 = draw_operand(b_raw_q, NUM_MAX);
        case (level_q)
            LVL_1:   op = OP_ADD + 4'(int'(op_raw_q) % 3);
            LVL_2:   op = OP_ADD + {2'b00, op_raw_q};
            default: op = OP_ADD + {3'b000, op_raw_q[0]};
        endcase

        // Division is issued as (q*d)/d so the quotient is always exact.
        prod       = 7'(a0) * 7'(b0);
        div_fits   = (prod <= 7'(NUM_MAX));
        div_reject = (op == OP_DIV) && !div_fits && (retry_q != RETRY_LIM);

        a_fix = a0;
        b_fix = b0;
        if (op == OP_SUB && a0 < b0) begin
            a_fix = b0;
            b_fix = a0;
        end else if (op == OP_DIV) begin
            if (div_fits) a_fix = prod[3:0];
            else          b_fix = 4'd1;
        end

        l0        = 2'(int'(ln_raw_q) % LANES);
        lane_pick = (l0 == prev_lane_q) ? 2'((int'(l0) + 1) % LANES) : l0;
    end

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        a_raw_d     = a_raw_q;
        b_raw_d     = b_raw_q;
        op_raw_d    = op_raw_q;
        ln_raw_d    = ln_raw_q;
        retry_d     = retry_q;
        exp_d       = exp_q;
        lane_d      = lane_q;
        prev_lane_d = prev_lane_q;
        valid_d     = valid_q;

        case (state_q)
            ST_DRAW: begin
                a_raw_d  = lfsr_lo[5:0];
                b_raw_d  = lfsr_lo[11:6];
                op_raw_d = lfsr_lo[13:12];
                ln_raw_d = lfsr_lo[15:14];
                if (int'(score) < THRESH1)      level_d = LVL_0;
                else if (int'(score) < THRESH2) level_d = LVL_1;
                else                            level_d = LVL_2;
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (div_reject) begin
                    retry_d = retry_q + 1'b1;
                    state_d = ST_DRAW;
                end else begin
                    exp_d       = {a_fix, op, b_fix};
                    lane_d      = lane_pick;
                    prev_lane_d = lane_pick;
                    valid_d     = 1'b1;
                    state_d     = ST_VALID;
                end
            end
            ST_VALID: begin
                if (out_if.out_ready) begin
                    valid_d = 1'b0;
                    retry_d = '0;
                    state_d = ST_DRAW;
                end
            end
            default: state_d = ST_DRAW;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_DRAW;
            level_q     <= LVL_0;
            a_raw_q     <= '0;
            b_raw_q     <= '0;
            op_raw_q    <= '0;
            ln_raw_q    <= '0;
            retry_q     <= '0;
            exp_q       <= 12'h000;
            lane_q      <= '0;
            prev_lane_q <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            a_raw_q     <= a_raw_d;
            b_raw_q     <= b_raw_d;
            op_raw_q    <= op_raw_d;
            ln_raw_q    <= ln_raw_d;
            retry_q     <= retry_d;
            exp_q       <= exp_d;
            lane_q      <= lane_d;
            prev_lane_q <= prev_lane_d;
            valid_q     <= valid_d;
        end
    end

    assign out_if.out_valid = valid_q;
    assign out_if.exp       = exp_q;
    assign out_if.lane      = lane_q;
endmodule

// File: tb/tb_expr_stream_gen.sv
// Bench for expr_stream_gen: two parameterisations checked against a transaction-level model.
module tb_expr_stream_gen;
    localparam int SEQ_N = 16600;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] score = '0;
`ifdef EXPR_GEN_SEED_EN
    logic        seed_load0 = 1'b0;
    logic [15:0] seed0      = '0;
    logic        seed_load1 = 1'b0;
    logic [23:0] seed1      = '0;
`endif

    always #5 clk = ~clk;

    expr_stream_gen_if s0 ();
    expr_stream_gen_if s1 ();

    expr_stream_gen u0 (
        .clk       (clk),
        .rst       (rst),
        .score     (score),
`ifdef EXPR_GEN_SEED_EN
        .seed_load (seed_load0),
        .seed      (seed0),
`endif
        .out_if    (s0)
    );

    expr_stream_gen #(
        .LFSR_W    (24),
        .SEED      (32'h00C0_FFEE),
        .NUM_MAX   (2),
        .LANES     (4),
        .MAX_RETRY (1)
    ) u1 (
        .clk       (clk),
        .rst       (rst),
        .score     (score),
`ifdef EXPR_GEN_SEED_EN
        .seed_load (seed_load1),
        .seed      (seed1),
`endif
        .out_if    (s1)
    );

    // Per-instance parameters as seen by the model.
    int          nmax [2]   = '{9, 2};
    int          lanes [2]  = '{3, 4};
    int          maxr [2]   = '{7, 1};
    int          w [2]      = '{16, 24};
    logic [31:0] seed_m [2] = '{32'h0000_ACE1, 32'h00C0_FFEE};

    logic [31:0] seq [2][SEQ_N];
    logic [11:0] exp_e [2];
    logic [1:0]  lane_e [2];
    int          load_e [2], prev_lane [2], last_lane [2], ndone [2], xfer_edge [2], forced [2];
    logic        prev_v [2];
    logic [3:0]  seen [2];
    bit          rdy [2];
    int          n, rmode;
    int          vecs = 0, errs = 0;

    typedef struct {
        int         score;
        int         rmode;
        int         ntrans;
        logic [3:0] mask;
    } row_t;
    row_t tbl [7];

    task automatic cmp(string name, int act, int req);
        vecs++;
        if (act != req) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_le(string name, int act, int lim);
        vecs++;
        if (act > lim) begin
            errs++;
            $display("FAIL %s: got %0d, expected <= %0d (t=%0t)", name, act, lim, $time);
        end
    endtask

    // Polynomial x^e terms read as bits (e-1) of the current state.
    function automatic logic [31:0] step(logic [31:0] v, int width);
        logic        fb;
        logic [31:0] r;
        case (width)
            24:      fb = v[23] ^ v[22] ^ v[21] ^ v[16];
            32:      fb = v[31] ^ v[21] ^ v[1] ^ v[0];
            default: fb = v[15] ^ v[13] ^ v[12] ^ v[10];
        endcase
        r = (v << 1) | {31'b0, fb};
        if (width < 32) r = r & ((32'h1 << width) - 32'h1);
        return r;
    endfunction

    // seq[i][k] is the LFSR value after k clock edges since reset release.
    task automatic build_seq(int i, bit sl, logic [31:0] sv);
        seq[i][0] = seed_m[i];
        if (sl) seq[i][1] = (sv == 32'h0) ? seed_m[i] : sv;
        else    seq[i][1] = step(seed_m[i], w[i]);
        for (int k = 2; k < SEQ_N; k++) seq[i][k] = step(seq[i][k-1], w[i]);
    endtask

    // Next expression when its first draw samples seq[i][k0]; a redraw costs two edges.
    task automatic predict(int i, int k0);
        int          k, r, a0, b0, opi, a, b, l0, ln, lvl;
        logic [31:0] v;
        bit          done;
        k = k0; r = 0; done = 1'b0;
        a = 0; b = 0; opi = 0; v = '0;
        while (!done) begin
            if (k >= SEQ_N) k = SEQ_N - 1;
            v   = seq[i][k];
            a0  = int'(v[5:0]) % nmax[i] + 1;
            b0  = int'(v[11:6]) % nmax[i] + 1;
            lvl = (int'(score) < 10) ? 0 : (int'(score) < 20) ? 1 : 2;
            opi = (lvl == 0) ? int'(v[13:12]) % 2 : (lvl == 1) ? int'(v[13:12]) % 3 : int'(v[13:12]);
            a = a0; b = b0; done = 1'b1;
            if (opi == 1 && a0 < b0) begin
                a = b0; b = a0;
            end else if (opi == 3) begin
                if (a0 * b0 <= nmax[i]) a = a0 * b0;
                else if (r == maxr[i]) begin b = 1; forced[i]++; end
                else begin r++; k += 2; done = 1'b0; end
            end
        end
        l0 = int'(v[15:14]) % lanes[i];
        ln = (l0 == prev_lane[i]) ? (l0 + 1) % lanes[i] : l0;
        prev_lane[i] = ln;
        exp_e[i]     = {4'(a), 4'(10 + opi), 4'(b)};
        lane_e[i]    = 2'(ln);
        load_e[i]    = k + 2;
    endtask

    task automatic props(int i, logic [11:0] e, logic [1:0] l);
        int a, b, op;
        a = int'(e[11:8]); op = int'(e[7:4]); b = int'(e[3:0]);
        check_le($sformatf("lane_range[%0d]", i), int'(l), lanes[i] - 1);
        cmp($sformatf("lane_repeat[%0d]", i), int'(l == 2'(last_lane[i])), 0);
        if (int'(score) < 10) cmp($sformatf("op_level0[%0d]", i), int'(op == 10 || op == 11), 1);
        if (int'(score) < 20) cmp($sformatf("op_no_div[%0d]", i), int'(op == 13), 0);
        if (op == 11) check_le($sformatf("sub_order[%0d]", i), b, a);
        if (op == 13) begin
            cmp($sformatf("div_by_zero[%0d]", i), int'(b == 0), 0);
            if (b != 0) cmp($sformatf("div_exact[%0d]", i), a % b, 0);
            check_le($sformatf("div_range[%0d]", i), a, nmax[i]);
        end
        if (op >= 10 && op <= 13) seen[i] = seen[i] | 4'(1 << (op - 10));
        last_lane[i] = int'(l);
    endtask

    task automatic check(int i, logic v, logic [11:0] e, logic [1:0] l);
        bit r;
        if (v && !prev_v[i]) check_le($sformatf("valid_gap[%0d]", i), n - xfer_edge[i], 2 * (maxr[i] + 1));
        prev_v[i] = v;
        if (n < load_e[i]) begin
            cmp($sformatf("valid_low[%0d] n=%0d", i, n), int'(v), 0);
        end else begin
            cmp($sformatf("valid_high[%0d] n=%0d", i, n), int'(v), 1);
            cmp($sformatf("exp[%0d] n=%0d", i, n), int'(e), int'(exp_e[i]));
            cmp($sformatf("lane[%0d] n=%0d", i, n), int'(l), int'(lane_e[i]));
            if (n == load_e[i]) props(i, e, l);
        end
        case (rmode)
            0:       r = ($urandom_range(7) != 0);
            1:       r = 1'b0;
            default: r = 1'b1;
        endcase
        rdy[i] = r;
        if (n >= load_e[i] && r) begin
            ndone[i]++;
            xfer_edge[i] = n + 1;
            predict(i, n + 1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        n++;
        #1;
        check(0, s0.out_valid, s0.exp, s0.lane);
        check(1, s1.out_valid, s1.exp, s1.lane);
        s0.out_ready = rdy[0];
        s1.out_ready = rdy[1];
    endtask

    task automatic do_reset(bit sl, logic [31:0] sv);
        @(posedge clk);
        #1;
        rst = 1'b0;
        s0.out_ready = 1'b0;
        s1.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        build_seq(0, sl, sv);
        build_seq(1, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            prev_lane[i] = 0; last_lane[i] = 0; prev_v[i] = 1'b0;
            xfer_edge[i] = 0; seen[i] = '0; ndone[i] = 0;
            predict(i, 0);
        end
        n = 0;
`ifdef EXPR_GEN_SEED_EN
        seed_load0 = sl;
        seed0      = sv[15:0];
`endif
        rst = 1'b1;
    endtask

    initial begin
        int cyc, budget;
        s0.out_ready = 1'b0;
        s1.out_ready = 1'b0;
        forced = '{0, 0};
        rmode  = 2;

        tbl[0] = '{0,   2, 150,  4'h3};
        tbl[1] = '{9,   0, 150,  4'h3};
        tbl[2] = '{10,  0, 150,  4'h7};
        tbl[3] = '{19,  0, 150,  4'h7};
        tbl[4] = '{20,  0, 150,  4'hF};
        tbl[5] = '{127, 0, 150,  4'hF};
        tbl[6] = '{25,  0, 2000, 4'hF};

        for (int t = 0; t < 7; t++) begin
            score = 7'(tbl[t].score);
            rmode = tbl[t].rmode;
            do_reset(1'b0, 32'h0);
            budget = tbl[t].ntrans * 8 + 64;
            cyc = 0;
            while (ndone[0] < tbl[t].ntrans && cyc < budget) begin
                tick();
                cyc++;
            end
            cmp($sformatf("transfers_in_budget row%0d", t), int'(ndone[0] >= tbl[t].ntrans), 1);
            cmp($sformatf("ops_seen[0] row%0d", t), int'(seen[0]), int'(tbl[t].mask));
            cmp($sformatf("ops_seen[1] row%0d", t), int'(seen[1]), int'(tbl[t].mask));
        end

        // Held expression must ignore score changes while waiting for the consumer.
        score = '0;
        rmode = 1;
        do_reset(1'b0, 32'h0);
        tick();
        tick();
        for (int c = 0; c < 50; c++) begin
            score = (score == 7'd0) ? 7'd30 : 7'd0;
            tick();
        end
        score = '0;

        // Asynchronous reset while holding an expression.
        rmode = 1;
        do_reset(1'b0, 32'h0);
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        cmp("rst_valid[0]", int'(s0.out_valid), 0);
        cmp("rst_exp[0]", int'(s0.exp), 0);
        cmp("rst_lane[0]", int'(s0.lane), 0);
        cmp("rst_valid[1]", int'(s1.out_valid), 0);
        cmp("rst_exp[1]", int'(s1.exp), 0);
        rmode = 2;
        do_reset(1'b0, 32'h0);
        repeat (30) tick();

`ifdef EXPR_GEN_SEED_EN
        begin
            logic [31:0] sv_tbl [3];
            sv_tbl = '{32'h1234, 32'h1234, 32'h0};
            score = 7'd25;
            rmode = 0;
            for (int j = 0; j < 3; j++) begin
                do_reset(1'b1, sv_tbl[j]);
                tick();
                seed_load0 = 1'b0;
                repeat (80) tick();
            end
        end
`endif

        $display("forced division fallbacks: inst0=%0d inst1=%0d", forced[0], forced[1]);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
